// File: rtl/scan_sequencer_if.sv
// Handshake bundle between a scan controller and the row-scan sequencer.
// The master drives scan requests; the slave (the sequencer) drives decoder outputs.
interface scan_sequencer_if;
   logic       start;
   logic       stop;
   logic       mode;
   logic [7:0] mask;
   logic [2:0] sel;
   logic       e;
   logic       row_tick;
   logic       frame_done;
   logic       busy;

   modport master (
      output start, stop, mode, mask,
      input  sel, e, row_tick, frame_done, busy
   );

   modport slave (
      input  start, stop, mode, mask,
      output sel, e, row_tick, frame_done, busy
   );
endinterface

// File: rtl/scan_sequencer.sv
// Row-scan sequencer feeding a 3-to-8 decoder: dwells on each enabled row of an
// 8-row field, separated by one blank cycle, with continuous or single-frame scanning.
module scan_sequencer #(
   parameter int unsigned DWELL = 4
) (
   input logic             clk,
   input logic             rst_n,
   scan_sequencer_if.slave bus
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StScan  = 2'd1;
   localparam logic [1:0] StBlank = 2'd2;

   localparam logic [7:0] LastCnt = 8'(DWELL - 1);

   logic [1:0] state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] frame_mask_q, frame_mask_d;
   logic       eof_q, eof_d;
   logic       to_idle_q, to_idle_d;

   logic [7:0] above;
   logic       has_next;

   function automatic logic [2:0] lowest_row(input logic [7:0] m);
      lowest_row = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (m[i]) lowest_row = 3'(i);
      end
   endfunction

   // Rows strictly above the current one; the search never wraps inside a frame.
   assign above    = frame_mask_q & (8'hFE << sel_q);
   assign has_next = |above;

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      frame_mask_d = frame_mask_q;
      eof_d        = eof_q;
      to_idle_d    = to_idle_q;
      if (bus.stop) begin
         state_d   = StIdle;
         sel_d     = 3'd0;
         cnt_d     = 8'd0;
         eof_d     = 1'b0;
         to_idle_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               sel_d = 3'd0;
               cnt_d = 8'd0;
               if (bus.start && (bus.mask != 8'd0)) begin
                  frame_mask_d = bus.mask;
                  sel_d        = lowest_row(bus.mask);
                  state_d      = StScan;
               end
            end
            StScan: begin
               if (cnt_q == LastCnt) begin
                  cnt_d   = 8'd0;
                  state_d = StBlank;
                  if (has_next) begin
                     sel_d     = lowest_row(above);
                     eof_d     = 1'b0;
                     to_idle_d = 1'b0;
                  end else begin
                     eof_d = 1'b1;
                     if (!bus.mode) begin
                        frame_mask_d = bus.mask;
                        sel_d        = lowest_row(bus.mask);
                        to_idle_d    = (bus.mask == 8'd0);
                     end else begin
                        sel_d     = 3'd0;
                        to_idle_d = 1'b1;
                     end
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            StBlank: begin
               cnt_d     = 8'd0;
               eof_d     = 1'b0;
               to_idle_d = 1'b0;
               state_d   = to_idle_q ? StIdle : StScan;
               if (to_idle_q) sel_d = 3'd0;
            end
            default: begin
               state_d = StIdle;
               sel_d   = 3'd0;
               cnt_d   = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         sel_q        <= 3'd0;
         cnt_q        <= 8'd0;
         frame_mask_q <= 8'd0;
         eof_q        <= 1'b0;
         to_idle_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         cnt_q        <= cnt_d;
         frame_mask_q <= frame_mask_d;
         eof_q        <= eof_d;
         to_idle_q    <= to_idle_d;
      end
   end

   // Outputs decode registered state only, so no input reaches an output combinationally.
   assign bus.sel        = sel_q;
   assign bus.e          = (state_q == StScan);
   assign bus.row_tick   = (state_q == StScan) && (cnt_q == LastCnt);
   assign bus.frame_done = (state_q == StBlank) && eof_q;
   assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer: whole-frame expected traces are derived from
// the enabled-row lists and checked cycle by cycle by an independent monitor.
module tb_scan_sequencer;
   localparam int unsigned DWELL = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   scan_sequencer_if bus_if ();

   scan_sequencer #(.DWELL(DWELL)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
   );

   typedef logic [6:0] obs_t;  // {sel, e, row_tick, frame_done, busy}
   localparam obs_t IdleObs = 7'd0;

   obs_t       exp_q[$];
   logic [7:0] frame_masks[$];
   int         tests_run = 0;
   int         tests_failed = 0;
   obs_t       mon_want, mon_got;

   function automatic obs_t mk(int sel, bit e, bit tick, bit fd, bit busy);
      return {3'(sel), e, tick, fd, busy};
   endfunction

   function automatic int low_row(logic [7:0] m);
      for (int i = 0; i < 8; i++) if (m[i]) return i;
      return 0;
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_want = exp_q.pop_front();
         mon_got  = {bus_if.sel, bus_if.e, bus_if.row_tick, bus_if.frame_done, bus_if.busy};
         tests_run++;
         if (mon_got !== mon_want) begin
            tests_failed++;
            $display("FAIL outputs @%0t: got sel=%0d e=%b tick=%b fd=%b busy=%b, want sel=%0d e=%b tick=%b fd=%b busy=%b",
                     $time, mon_got[6:4], mon_got[3], mon_got[2], mon_got[1], mon_got[0],
                     mon_want[6:4], mon_want[3], mon_want[2], mon_want[1], mon_want[0]);
         end
      end
   end

   task automatic drive(bit st, bit sp, bit md, logic [7:0] m);
      bus_if.start = st;
      bus_if.stop  = sp;
      bus_if.mode  = md;
      bus_if.mask  = m;
   endtask

   // A request that must leave the sequencer idle for the following cycles.
   task automatic idle_check(bit st, bit sp, logic [7:0] m);
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) exp_q.push_back(IdleObs);
      drive(st, sp, 1'($urandom), m);
      for (int t = 1; t < 5; t++) begin
         @(posedge clk);
         #1;
         drive(1'b0, 1'b0, 1'($urandom), 8'($urandom));
      end
   endtask

   // Plays the frames in frame_masks. end_mode=1 ends via mode=1, 0 via an empty mask.
   // abort_kind: 0 none, 1 stop during cycle abort_at, 2 async reset during abort_at.
   task automatic run_scenario(bit end_mode, int abort_kind, int abort_at, bit noise);
      obs_t       tr[$];
      int         last_dw[$];
      int         rows[$];
      int         n;
      int         nxt;
      logic [7:0] m;
      bit         md, st, sp;
      n = frame_masks.size();
      tr.push_back(IdleObs);
      for (int f = 0; f < n; f++) begin
         rows = {};
         for (int i = 0; i < 8; i++) if (frame_masks[f][i]) rows.push_back(i);
         for (int j = 0; j < rows.size(); j++) begin
            for (int d = 0; d < int'(DWELL); d++)
               tr.push_back(mk(rows[j], 1'b1, d == int'(DWELL) - 1, 1'b0, 1'b1));
            if (j < rows.size() - 1) begin
               tr.push_back(mk(rows[j + 1], 1'b0, 1'b0, 1'b0, 1'b1));
            end else begin
               last_dw.push_back(tr.size() - 1);
               nxt = (f < n - 1) ? low_row(frame_masks[f + 1]) : 0;
               tr.push_back(mk(nxt, 1'b0, 1'b0, 1'b1, 1'b1));
            end
         end
      end
      for (int i = 0; i < 3; i++) tr.push_back(IdleObs);
      if (abort_kind == 1) for (int i = abort_at + 1; i < tr.size(); i++) tr[i] = IdleObs;
      if (abort_kind == 2) for (int i = abort_at; i < tr.size(); i++) tr[i] = IdleObs;

      @(posedge clk);
      #1;
      foreach (tr[i]) exp_q.push_back(tr[i]);
      for (int t = 0; t < tr.size(); t++) begin
         if (t > 0) begin
            @(posedge clk);
            #1;
         end
         m  = 8'($urandom);
         md = 1'($urandom);
         st = 1'b0;
         sp = (abort_kind == 1) && (t == abort_at);
         if (t == 0) begin
            m  = frame_masks[0];
            st = 1'b1;
         end else begin
            for (int f = 0; f < n; f++) begin
               if (last_dw[f] == t) begin
                  if (f < n - 1) begin
                     m  = frame_masks[f + 1];
                     md = 1'b0;
                  end else begin
                     md = end_mode;
                     if (!end_mode) m = 8'd0;
                  end
               end
            end
            st = noise && tr[t][0] && ($urandom_range(0, 3) == 0);
         end
         drive(st, sp, md, m);
         if (abort_kind == 2 && t == abort_at) begin
            #1;
            rst_n = 1'b0;
         end
         if (abort_kind == 2 && t == abort_at + 2) rst_n = 1'b1;
      end
   endtask

   initial begin
      int nf;
      drive(1'b0, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 3; i++) exp_q.push_back(IdleObs);
      repeat (3) @(negedge clk);
      #1;
      rst_n = 1'b1;

      frame_masks = {8'hFF};
      run_scenario(1'b1, 0, 0, 1'b0);
      frame_masks = {8'hA4, 8'hA4, 8'h01};
      run_scenario(1'b0, 0, 0, 1'b1);
      frame_masks = {8'h80, 8'h80, 8'h80};
      run_scenario(1'b1, 0, 0, 1'b1);
      frame_masks = {8'hFF};
      run_scenario(1'b1, 1, 17, 1'b0);
      idle_check(1'b1, 1'b1, 8'hFF);
      idle_check(1'b1, 1'b0, 8'h00);
      frame_masks = {8'h3C, 8'h3C};
      run_scenario(1'b1, 0, 0, 1'b1);
      frame_masks = {8'hFF};
      run_scenario(1'b1, 2, 7, 1'b0);
      idle_check(1'b0, 1'b0, 8'hFF);

      for (int s = 0; s < 25; s++) begin
         nf = $urandom_range(1, 3);
         frame_masks = {};
         for (int f = 0; f < nf; f++) frame_masks.push_back(8'($urandom_range(1, 255)));
         run_scenario(1'($urandom), $urandom_range(0, 2),
                      $urandom_range(1, int'(DWELL) + 1), 1'b1);
      end

      @(negedge clk);
      #1;
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
